// File: rtl/ttt_game_ctrl_if.sv
// Game-controller bus: start/turn handshake, AI lookup input and board/result outputs.
interface ttt_game_ctrl_if;
  logic       start;
  logic       player_valid;
  logic [8:0] player_move;
  logic       player_ready;
  logic [8:0] ai_move;
  logic [8:0] x_state;
  logic [8:0] o_state;
  logic       illegal;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output start, player_valid, player_move, ai_move,
    input  player_ready, x_state, o_state, illegal, game_over, winner
  );

  modport slave (
    input  start, player_valid, player_move, ai_move,
    output player_ready, x_state, o_state, illegal, game_over, winner
  );
endinterface

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn controller: AI plays X (with fallback), player plays O.
// Optional player-move forfeit timer enabled by defining TTT_MOVE_TIMEOUT_EN.
module ttt_game_ctrl #(
  parameter int AI_WAIT        = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic           clk,
  input logic           rst_n,
  ttt_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, AI_WAIT_S, AI_APPLY, CHECK_X, PLAYER, CHECK_O, DONE
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(AI_WAIT);

  state_t     state, state_next;
  logic [8:0] x_board, x_next;
  logic [8:0] o_board, o_next;
  logic [1:0] result, result_next;
  logic       illegal_flag, illegal_next;
  logic [3:0] wait_cnt, wait_next;
  logic [8:0] occupied;
  logic       move_ok;
  logic       ai_ok;

`ifdef TTT_MOVE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TO_W-1:0] to_cnt, to_next;
  logic            timeout_hit;
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  function automatic logic is_onehot(input logic [8:0] v);
    return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

  function automatic logic has_line(input logic [8:0] b);
    return ((b & 9'h1C0) == 9'h1C0) || ((b & 9'h038) == 9'h038) ||
           ((b & 9'h007) == 9'h007) || ((b & 9'h124) == 9'h124) ||
           ((b & 9'h092) == 9'h092) || ((b & 9'h049) == 9'h049) ||
           ((b & 9'h111) == 9'h111) || ((b & 9'h054) == 9'h054);
  endfunction

  // Later (higher) indices overwrite earlier ones, so the top empty cell wins.
  function automatic logic [8:0] highest_empty(input logic [8:0] empty);
    logic [8:0] pick;
    pick = 9'd0;
    for (int i = 0; i < 9; i++) begin
      if (empty[i]) pick = 9'd1 << i;
    end
    return pick;
  endfunction

  assign occupied = x_board | o_board;
  assign move_ok  = is_onehot(bus.player_move) && ((bus.player_move & occupied) == 9'd0);
  assign ai_ok    = is_onehot(bus.ai_move) && ((bus.ai_move & occupied) == 9'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      x_board      <= 9'd0;
      o_board      <= 9'd0;
      result       <= 2'b00;
      illegal_flag <= 1'b0;
      wait_cnt     <= 4'd0;
`ifdef TTT_MOVE_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      state        <= state_next;
      x_board      <= x_next;
      o_board      <= o_next;
      result       <= result_next;
      illegal_flag <= illegal_next;
      wait_cnt     <= wait_next;
`ifdef TTT_MOVE_TIMEOUT_EN
      to_cnt       <= to_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    x_next       = x_board;
    o_next       = o_board;
    result_next  = result;
    illegal_next = 1'b0;
    wait_next    = wait_cnt;
`ifdef TTT_MOVE_TIMEOUT_EN
    to_next      = to_cnt;
`endif
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          x_next      = 9'd0;
          o_next      = 9'd0;
          result_next = 2'b00;
          wait_next   = WAIT_LOAD;
          state_next  = AI_WAIT_S;
        end
      end
      AI_WAIT_S: begin
        if (wait_cnt <= 4'd1) begin
          wait_next  = 4'd0;
          state_next = AI_APPLY;
        end else begin
          wait_next = wait_cnt - 4'd1;
        end
      end
      AI_APPLY: begin
        x_next     = x_board | (ai_ok ? bus.ai_move : highest_empty(~occupied));
        state_next = CHECK_X;
      end
      CHECK_X: begin
        if (has_line(x_board)) begin
          result_next = 2'b01;
          state_next  = DONE;
        end else if (occupied == 9'h1FF) begin
          result_next = 2'b00;
          state_next  = DONE;
        end else begin
          state_next = PLAYER;
`ifdef TTT_MOVE_TIMEOUT_EN
          to_next    = '0;
`endif
        end
      end
      PLAYER: begin
        // An accepted move beats a timer expiring in the same cycle.
        if (bus.player_valid && move_ok) begin
          o_next     = o_board | bus.player_move;
          state_next = CHECK_O;
        end else begin
          if (bus.player_valid) illegal_next = 1'b1;
`ifdef TTT_MOVE_TIMEOUT_EN
          if (timeout_hit) begin
            result_next = 2'b01;
            state_next  = DONE;
          end else begin
            to_next = to_cnt + 1'b1;
          end
`endif
        end
      end
      CHECK_O: begin
        if (has_line(o_board)) begin
          result_next = 2'b10;
          state_next  = DONE;
        end else if (occupied == 9'h1FF) begin
          result_next = 2'b00;
          state_next  = DONE;
        end else begin
          wait_next  = WAIT_LOAD;
          state_next = AI_WAIT_S;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.x_state      = x_board;
  assign bus.o_state      = o_board;
  assign bus.player_ready = (state == PLAYER);
  assign bus.game_over    = (state == DONE);
  assign bus.winner       = result;
  assign bus.illegal      = illegal_flag;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: directed vector table, random games
// against a cell-array reference model, and draw/reset/timeout sequences.
module tb_ttt_game_ctrl;
  localparam int AI_WAIT        = 2;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int NV             = 22;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ttt_game_ctrl_if bus();

  ttt_game_ctrl #(.AI_WAIT(AI_WAIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       pv;
    logic [8:0] pm;
    logic [8:0] ai;
    logic [8:0] ex;
    logic [8:0] eo;
    logic       eill;
    logic       erdy;
    logic       eover;
    logic [1:0] ewin;
  } vec_t;

  vec_t vecs[NV];
  int   checks   = 0;
  int   failures = 0;
  int   cells[9];
  int   lines[8][3] = '{'{8,7,6}, '{5,4,3}, '{2,1,0}, '{8,5,2},
                        '{7,4,1}, '{6,3,0}, '{8,4,0}, '{6,4,2}};
  int   x_script[5] = '{8, 6, 1, 5, 0};
  int   o_script[4] = '{4, 7, 2, 3};

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic pv, input logic [8:0] pm,
                               input logic [8:0] ai);
    bus.start        = s;
    bus.player_valid = pv;
    bus.player_move  = pm;
    bus.ai_move      = ai;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: cells[] holds 0 empty, 1 X, 2 O.
  function automatic logic [8:0] board_of(input int who);
    logic [8:0] b;
    b = 9'd0;
    for (int i = 0; i < 9; i++) if (cells[i] == who) b[i] = 1'b1;
    return b;
  endfunction

  function automatic bit model_line(input int who);
    for (int l = 0; l < 8; l++)
      if (cells[lines[l][0]] == who && cells[lines[l][1]] == who && cells[lines[l][2]] == who)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < 9; i++) if (cells[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_ai(input logic [8:0] ai);
    int pos;
    pos = -1;
    if ($countones(ai) == 1)
      for (int i = 0; i < 9; i++) if (ai[i]) pos = i;
    if (pos < 0 || cells[pos] != 0) begin
      pos = -1;
      for (int i = 8; i >= 0; i--) if (pos < 0 && cells[i] == 0) pos = i;
    end
    if (pos >= 0) cells[pos] = 1;
  endtask

  function automatic logic [8:0] rand_empty_bit();
    int q[$];
    for (int i = 0; i < 9; i++) if (cells[i] == 0) q.push_back(i);
    if (q.size() == 0) return 9'd0;
    return 9'd1 << q[$urandom_range(0, q.size() - 1)];
  endfunction

  function automatic logic [8:0] two_bits();
    int a, b;
    a = $urandom_range(0, 8);
    b = (a + $urandom_range(1, 8)) % 9;
    return (9'd1 << a) | (9'd1 << b);
  endfunction

  function automatic logic [8:0] pick_ai();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return rand_empty_bit();
    if (r == 6) return 9'd0;
    if (r == 7) return 9'd1 << $urandom_range(0, 8);
    if (r == 8) return two_bits();
    return 9'($urandom);
  endfunction

  function automatic logic [8:0] pick_bad();
    int r;
    int q[$];
    r = $urandom_range(0, 2);
    if (r == 0) return 9'd0;
    if (r == 1) return two_bits();
    for (int i = 0; i < 9; i++) if (cells[i] != 0) q.push_back(i);
    return 9'd1 << q[$urandom_range(0, q.size() - 1)];
  endfunction

  task automatic check_board(input string tag);
    checkOutput({tag, "_x"}, 32'(bus.x_state), 32'(board_of(1)));
    checkOutput({tag, "_o"}, 32'(bus.o_state), 32'(board_of(2)));
  endtask

  task automatic wait_turn(input logic [8:0] ai, output int n);
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 9'd0, ai);
      n++;
    end while (!(bus.player_ready || bus.game_over) && n < 100);
  endtask

  task automatic play_game(input bit scripted);
    int         n, exp_lat, turn;
    logic [8:0] ai, good;
    applyStimulus(1'b1, 1'b0, 9'd0, 9'd0);
    for (int i = 0; i < 9; i++) cells[i] = 0;
    check_board("start");
    checkOutput("start_over", 32'(bus.game_over), 32'd0);
    exp_lat = AI_WAIT + 2;
    turn    = 0;
    while (turn < 9) begin
      ai = scripted ? (9'd1 << x_script[turn]) : pick_ai();
      model_ai(ai);
      wait_turn(ai, n);
      checkOutput("turn_latency", 32'(n), 32'(exp_lat));
      if (!(bus.player_ready || bus.game_over)) break;
      check_board("ai");
      if (model_line(1) || model_full()) begin
        checkOutput("x_end_over", 32'(bus.game_over), 32'd1);
        checkOutput("x_end_winner", 32'(bus.winner), model_line(1) ? 32'd1 : 32'd0);
        checkOutput("x_end_ready", 32'(bus.player_ready), 32'd0);
        break;
      end
      checkOutput("player_ready", 32'(bus.player_ready), 32'd1);
      if (!scripted && $urandom_range(0, 2) == 0) begin
        applyStimulus(1'b0, 1'b1, pick_bad(), 9'd0);
        checkOutput("illegal_pulse", 32'(bus.illegal), 32'd1);
        check_board("illegal");
        checkOutput("ready_after_illegal", 32'(bus.player_ready), 32'd1);
      end
      good = scripted ? (9'd1 << o_script[turn]) : rand_empty_bit();
      for (int i = 0; i < 9; i++) if (good[i]) cells[i] = 2;
      applyStimulus(1'b0, 1'b1, good, 9'd0);
      checkOutput("accept_illegal", 32'(bus.illegal), 32'd0);
      check_board("player");
      checkOutput("accept_ready", 32'(bus.player_ready), 32'd0);
      if (model_line(2) || model_full()) begin
        applyStimulus(1'b0, 1'b0, 9'd0, 9'd0);
        checkOutput("o_end_over", 32'(bus.game_over), 32'd1);
        checkOutput("o_end_winner", 32'(bus.winner), model_line(2) ? 32'd2 : 32'd0);
        break;
      end
      exp_lat = AI_WAIT + 3;
      turn++;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    // X takes 100, fallback 080, then 040 while O plays 001/002 around two rejected moves.
    vecs[0]  = '{1'b1, 1'b0, 9'h000, 9'h100, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[1]  = '{1'b0, 1'b0, 9'h000, 9'h100, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[2]  = '{1'b0, 1'b0, 9'h000, 9'h100, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[3]  = '{1'b0, 1'b0, 9'h000, 9'h100, 9'h100, 9'h000, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[4]  = '{1'b0, 1'b0, 9'h000, 9'h100, 9'h100, 9'h000, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[5]  = '{1'b0, 1'b1, 9'h100, 9'h100, 9'h100, 9'h000, 1'b1, 1'b1, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 1'b1, 9'h003, 9'h100, 9'h100, 9'h000, 1'b1, 1'b1, 1'b0, 2'b00};
    vecs[7]  = '{1'b0, 1'b0, 9'h000, 9'h100, 9'h100, 9'h000, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[8]  = '{1'b0, 1'b1, 9'h001, 9'h100, 9'h100, 9'h001, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[9]  = '{1'b0, 1'b0, 9'h000, 9'h000, 9'h100, 9'h001, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[10] = '{1'b0, 1'b0, 9'h000, 9'h000, 9'h100, 9'h001, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[11] = '{1'b0, 1'b0, 9'h000, 9'h000, 9'h100, 9'h001, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[12] = '{1'b0, 1'b0, 9'h000, 9'h000, 9'h180, 9'h001, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[13] = '{1'b0, 1'b0, 9'h000, 9'h000, 9'h180, 9'h001, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[14] = '{1'b0, 1'b1, 9'h002, 9'h000, 9'h180, 9'h003, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[15] = '{1'b0, 1'b0, 9'h000, 9'h040, 9'h180, 9'h003, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[16] = '{1'b0, 1'b0, 9'h000, 9'h040, 9'h180, 9'h003, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[17] = '{1'b0, 1'b0, 9'h000, 9'h040, 9'h180, 9'h003, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[18] = '{1'b0, 1'b0, 9'h000, 9'h040, 9'h1C0, 9'h003, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[19] = '{1'b0, 1'b0, 9'h000, 9'h040, 9'h1C0, 9'h003, 1'b0, 1'b0, 1'b1, 2'b01};
    vecs[20] = '{1'b0, 1'b1, 9'h004, 9'h040, 9'h1C0, 9'h003, 1'b0, 1'b0, 1'b1, 2'b01};
    vecs[21] = '{1'b0, 1'b0, 9'h000, 9'h040, 9'h1C0, 9'h003, 1'b0, 1'b0, 1'b1, 2'b01};

    bus.start = 1'b0; bus.player_valid = 1'b0; bus.player_move = 9'd0; bus.ai_move = 9'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_x", 32'(bus.x_state), 32'd0);
    checkOutput("rst_o", 32'(bus.o_state), 32'd0);
    checkOutput("rst_ready", 32'(bus.player_ready), 32'd0);
    checkOutput("rst_over", 32'(bus.game_over), 32'd0);
    checkOutput("rst_winner", 32'(bus.winner), 32'd0);
    checkOutput("rst_illegal", 32'(bus.illegal), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 9'h010, 9'd0);
    checkOutput("idle_ignore_ready", 32'(bus.player_ready), 32'd0);
    checkOutput("idle_ignore_illegal", 32'(bus.illegal), 32'd0);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].start, vecs[i].pv, vecs[i].pm, vecs[i].ai);
      checkOutput($sformatf("vec%0d_x", i), 32'(bus.x_state), 32'(vecs[i].ex));
      checkOutput($sformatf("vec%0d_o", i), 32'(bus.o_state), 32'(vecs[i].eo));
      checkOutput($sformatf("vec%0d_illegal", i), 32'(bus.illegal), 32'(vecs[i].eill));
      checkOutput($sformatf("vec%0d_ready", i), 32'(bus.player_ready), 32'(vecs[i].erdy));
      checkOutput($sformatf("vec%0d_over", i), 32'(bus.game_over), 32'(vecs[i].eover));
      checkOutput($sformatf("vec%0d_winner", i), 32'(bus.winner), 32'(vecs[i].ewin));
    end

    repeat (30) play_game(1'b0);

    play_game(1'b1);
    checkOutput("draw_x", 32'(bus.x_state), 32'h163);
    checkOutput("draw_o", 32'(bus.o_state), 32'h09C);
    checkOutput("draw_over", 32'(bus.game_over), 32'd1);
    checkOutput("draw_winner", 32'(bus.winner), 32'd0);
    applyStimulus(1'b1, 1'b0, 9'd0, 9'd0);
    checkOutput("restart_x", 32'(bus.x_state), 32'd0);
    checkOutput("restart_o", 32'(bus.o_state), 32'd0);
    checkOutput("restart_over", 32'(bus.game_over), 32'd0);
    checkOutput("restart_ready", 32'(bus.player_ready), 32'd0);

    wait_turn(9'h010, n);
    checkOutput("restart_latency", 32'(n), 32'(AI_WAIT + 2));
    checkOutput("restart_ai_x", 32'(bus.x_state), 32'h010);
    applyStimulus(1'b1, 1'b0, 9'd0, 9'd0);
    checkOutput("start_ignored_ready", 32'(bus.player_ready), 32'd1);
    checkOutput("start_ignored_x", 32'(bus.x_state), 32'h010);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_x", 32'(bus.x_state), 32'd0);
    checkOutput("async_rst_ready", 32'(bus.player_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 9'h001, 9'd0);
    checkOutput("post_rst_ready", 32'(bus.player_ready), 32'd0);
    checkOutput("post_rst_o", 32'(bus.o_state), 32'd0);
    checkOutput("post_rst_illegal", 32'(bus.illegal), 32'd0);
    checkOutput("post_rst_over", 32'(bus.game_over), 32'd0);

`ifdef TTT_MOVE_TIMEOUT_EN
    applyStimulus(1'b1, 1'b0, 9'd0, 9'd0);
    wait_turn(9'h010, n);
    checkOutput("to_entry_ready", 32'(bus.player_ready), 32'd1);
    for (int k = 1; k < TIMEOUT_CYCLES; k++) begin
      applyStimulus(1'b0, 1'b0, 9'd0, 9'd0);
      checkOutput($sformatf("to_wait%0d", k), 32'(bus.player_ready), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 9'd0, 9'd0);
    checkOutput("to_over", 32'(bus.game_over), 32'd1);
    checkOutput("to_winner", 32'(bus.winner), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 Parameter AI_WAIT, default 2, cycles the board is held stable before sampling ai_move (range 1-15).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000, player-move timeout in clocks (used only under REQ-030).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  pulse; begins a new game from IDLE or DONE.
REQ-006 player_valid  input  1  player move offered.
REQ-007 player_move  input  9  one-hot cell chosen by player (O).
REQ-008 player_ready  output  1  high only in PLAYER state.
REQ-009 ai_move  input  9  one-hot move from external AI lookup, combinational in x_state/o_state.
REQ-010 x_state  output  9  AI (X) occupancy; bit 8 top-left ... bit 0 bottom-right, row-major.
REQ-011 o_state  output  9  player (O) occupancy, same mapping.
REQ-012 illegal  output  1  one-cycle pulse on rejected player move.
REQ-013 game_over  output  1  high in DONE.
REQ-014 winner  output  2  00 none/draw, 01 X, 10 O; valid while game_over.

Function
REQ-015 States: IDLE, AI_WAIT_S, AI_APPLY, CHECK_X, PLAYER, CHECK_O, DONE.
REQ-016 IDLE/DONE + start -> clear boards, winner=00, go AI_WAIT_S; start ignored in other states.
REQ-017 AI_WAIT_S: counter loads AI_WAIT, decrements each cycle, boards frozen; at 0 -> AI_APPLY.
REQ-018 AI_APPLY: if ai_move is exactly one-hot and on an empty cell, OR it into x_state; else place X on the highest-index empty cell (fallback); -> CHECK_X.
REQ-019 CHECK_X: X has any of 8 lines (3 rows, 3 cols, 2 diags) -> DONE, winner=01; else board full -> DONE, winner=00; else -> PLAYER.
REQ-020 PLAYER: player_ready=1; on player_valid, accept only if player_move is one-hot and cell empty -> OR into o_state, -> CHECK_O, same cycle.
REQ-021 Rejected move (zero, multi-hot, or occupied): illegal pulses next cycle, boards unchanged, remain in PLAYER.
REQ-022 CHECK_O: O line -> DONE, winner=10; board full -> DONE, winner=00; else -> AI_WAIT_S.
REQ-023 Turn latency: AI move visible on x_state AI_WAIT+1 cycles after entering AI_WAIT_S; player move visible 1 cycle after acceptance.
REQ-024 x_state & o_state SHALL be 0 at all times; total popcount never exceeds 9.
REQ-025 DONE holds boards and winner until start.
REQ-026 player_valid outside PLAYER is ignored, no illegal pulse.

Reset
REQ-027 rst_n low asynchronously forces IDLE, x_state=0, o_state=0, winner=00, game_over=0, illegal=0, player_ready=0, counters=0.
REQ-028 Reset mid-game aborts the game; no move pending survives; start required afterwards.
REQ-029 Release of rst_n takes effect synchronously on the next rising clk edge.

Configuration
REQ-030 Macro TTT_MOVE_TIMEOUT_EN defined: PLAYER counts cycles from entry; at TIMEOUT_CYCLES without accepted move -> DONE, winner=01 (forfeit); counter resets on each PLAYER entry; a valid move on the expiry cycle takes priority.
REQ-031 Macro undefined: no timeout counter is built; PLAYER waits indefinitely.

Verification
REQ-032 rst_n low, start, ai_move=9'h100 -> after AI_WAIT+1 cycles x_state=9'h100, player_ready=1.
REQ-033 In PLAYER with x_state=9'h100, player_move=9'h100 -> illegal pulse, o_state unchanged; player_move=9'h003 -> illegal pulse.
REQ-034 X gets 9'h100, 9'h080, 9'h040 across turns with O at 9'h001, 9'h002 -> game_over=1, winner=01, player_ready=0.
REQ-035 ai_move=0 from lookup with board X=9'h100 -> fallback X at bit 7 (x_state=9'h180).
REQ-036 Full board with no line -> winner=00, game_over=1; start -> boards cleared, AI_WAIT_S entered.
REQ-037 With TTT_MOVE_TIMEOUT_EN, TIMEOUT_CYCLES=8, no player_valid -> DONE, winner=01 after 8 cycles in PLAYER; rst_n mid-PLAYER -> IDLE, boards 0.
